quiz_round_ctrl: RTL and testbench
==================================

Name: quiz_round_ctrl

Overview:
- Sequences the question rounds of the two-player quiz game and drives the score datapath (score_control).
- Runs the per-question countdown and arbitrates buzzers A and B, including simultaneous presses.
- Locks out a player who answered wrongly, collects the judge verdict, and issues exactly one score strobe (who/right) per answer.
- Stops at the question limit or when score_control asserts finish.

Parameters:
- COUNT_INIT, 30: countdown start value per question, 1..255.
- TICK_DIV, 100: clk cycles per countdown decrement, >=1.
- NUM_Q, 10: number of questions per game, 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; begins the game when sampled high in IDLE.
- buzzA  in  1  player A buzzer, synchronous level.
- buzzB  in  1  player B buzzer, synchronous level.
- judge_valid  in  1  one-cycle verdict strobe from the host.
- judge_right  in  1  verdict; qualified by judge_valid.
- finish  in  1  from score_control; game over.
- count  out  8  remaining time of the current question, to score_control.
- who  out  2  score strobe: 01 = A, 10 = B, 00 = none. 11 is never driven.
- right  out  1  verdict, valid only while who != 00.
- lock  out  2  current buzz owner (01/10) or 00.
- q_num  out  8  current question index, starting at 0.
- done  out  1  game over, held.

Behaviour:
- **Reset (rst = 0, asynchronous):**
  - State goes to IDLE.
  - Outputs: count = COUNT_INIT, who = 00, right = 0, lock = 00, q_num = 0, done = 0.
  - Tick prescaler = 0, exclusion flags exclA/exclB = 0, priority pointer = A.
  - Reset asserted mid-question aborts everything; no strobe is emitted.
- **States:** IDLE, OPEN, LOCKED, SCORE, DONE. All outputs are registered.
- **IDLE:**
  - start = 1 moves to OPEN on the next edge.
  - On that edge: count = COUNT_INIT, prescaler cleared, excl flags cleared.
- **OPEN:**
  - Prescaler counts 0..TICK_DIV-1. At wrap, count decrements.
  - If count == 0 at a wrap, the question times out and goes to NEXT handling. No strobe is issued.
  - An eligible buzz means buzzX = 1 and exclX = 0. On an eligible buzz the state goes to LOCKED and lock = the buzzing player.
  - Both eligible in the same cycle: the player named by the priority pointer wins. The pointer then moves to the other player (round-robin fairness).
  - A buzz in the same cycle as a timeout wrap: the buzz wins and count stays at its current value.
- **LOCKED:**
  - Countdown and prescaler are frozen.
  - Buzzer inputs are ignored.
  - judge_valid = 1 moves to SCORE.
- **SCORE:** lasts exactly one cycle.
  - who = lock, right = judge_right as captured in LOCKED.
  - On the next cycle: who = 00, right = 0, lock = 00.
  - If right = 1, or the other player is already excluded, go to NEXT handling.
  - Otherwise set exclX for the wrong player and return to OPEN. count and prescaler resume from their frozen values.
- **NEXT handling:**
  - If q_num == NUM_Q-1, go to DONE.
  - Otherwise q_num += 1, count = COUNT_INIT, excl flags cleared, and go to OPEN.
- **finish:**
  - finish = 1 in any state except IDLE forces DONE on the next edge.
  - If finish coincides with SCORE, the strobe is still emitted that cycle.
- **DONE:** done = 1, who = 00, count held. Exited only by reset.
- **Other rules:**
  - judge_valid outside LOCKED is ignored.
  - who is never nonzero for more than one consecutive cycle.

Decomposition:
- Shared package (quiz_pkg) holds:
  - State encoding constants.
  - WHO_NONE = 2'b00, WHO_A = 2'b01, WHO_B = 2'b10.
- Sub-module tick_prescaler provides:
  - Parameter TICK_DIV.
  - Inputs en and clr.
  - Output tick, a one-cycle pulse at wrap.

Test Plan (COUNT_INIT = 5, TICK_DIV = 1, NUM_Q = 2 unless stated):
- Reset, then start; no buzz -> count steps 5,4,3,2,1,0. The question times out with who = 00 throughout, q_num = 1, count reloads to 5.
- Start; buzzA at count = 3; judge_valid with judge_right = 1 -> lock = 01. count stays at 3 while LOCKED. A single cycle of who = 01, right = 1, then q_num = 1.
- buzzB; judge wrong -> one cycle of who = 10, right = 0, then OPEN resumes from the frozen count with exclB = 1. A further buzzB is ignored; buzzA is accepted, lock = 01.
- buzzA and buzzB in the same cycle, twice on consecutive questions -> the first winner is A (lock = 01), the second is B (lock = 10).
- Finish the second question -> done = 1 and stays 1. start and buzz inputs are ignored afterwards.
- finish asserted while LOCKED -> DONE next edge with no strobe. Separately, asserting rst low mid-OPEN -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round sequencer: FSM state codes and buzz-owner encodings.
// Pure declarations; no timing or flow-control behaviour of its own.
package quiz_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPEN   = 3'd1;
  localparam logic [2:0] ST_LOCKED = 3'd2;
  localparam logic [2:0] ST_SCORE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_A    = 2'b01;
  localparam logic [1:0] WHO_B    = 2'b10;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == WHO_A) ? WHO_B : WHO_A;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Countdown prescaler: counts enabled cycles 0..TICK_DIV-1 and pulses tick on the wrap cycle.
// tick is combinational in the wrap cycle; en low freezes the count, clr forces it to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]    LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Two-player quiz round sequencer: countdown, buzzer arbitration, lockout and one-cycle score strobe.
// All outputs registered (one-cycle latency from inputs); no backpressure, the judge strobe is taken only in LOCKED.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int COUNT_INIT = 30,
  parameter int TICK_DIV   = 100,
  parameter int NUM_Q      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       buzzA,
  input  logic       buzzB,
  input  logic       judge_valid,
  input  logic       judge_right,
  input  logic       finish,
  output logic [7:0] count,
  output logic [1:0] who,
  output logic       right,
  output logic [1:0] lock,
  output logic [7:0] q_num,
  output logic       done
);

  localparam logic [7:0] CNT_INIT = 8'(COUNT_INIT);
  localparam logic [7:0] Q_LAST   = 8'(NUM_Q - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] who_q, who_d;
  logic       right_q, right_d;
  logic [1:0] lock_q, lock_d;
  logic [7:0] q_num_q, q_num_d;
  logic       done_q, done_d;
  logic       excl_a_q, excl_a_d;
  logic       excl_b_q, excl_b_d;
  logic       prio_b_q, prio_b_d;

  logic elig_a;
  logic elig_b;
  logic any_elig;
  logic score_advance;
  logic go_next;
  logic pres_en;
  logic pres_clr;
  logic tick;

  assign elig_a   = buzzA & ~excl_a_q;
  assign elig_b   = buzzB & ~excl_b_q;
  assign any_elig = elig_a | elig_b;

  // A wrong answer only returns the question to the floor if the other player may still buzz.
  assign score_advance = right_q |
                         ((other_player(lock_q) == WHO_A) ? excl_a_q : excl_b_q);

  // A buzz freezes the prescaler in the same cycle so the count stays where it was.
  assign pres_en  = (state_q == ST_OPEN) & ~any_elig;
  assign pres_clr = (state_q == ST_IDLE) | ((state_q == ST_SCORE) & score_advance);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pres_en),
    .clr (pres_clr),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    who_d    = WHO_NONE;
    right_d  = 1'b0;
    lock_d   = lock_q;
    q_num_d  = q_num_q;
    excl_a_d = excl_a_q;
    excl_b_d = excl_b_q;
    prio_b_d = prio_b_q;
    go_next  = 1'b0;

    if (finish && (state_q != ST_IDLE)) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_OPEN;
            count_d  = CNT_INIT;
            excl_a_d = 1'b0;
            excl_b_d = 1'b0;
          end
        end

        ST_OPEN: begin
          if (any_elig) begin
            state_d = ST_LOCKED;
            if (elig_a && elig_b) begin
              lock_d   = prio_b_q ? WHO_B : WHO_A;
              prio_b_d = ~prio_b_q;
            end else begin
              lock_d = elig_a ? WHO_A : WHO_B;
            end
          end else if (tick) begin
            if (count_q == 8'd0) begin
              go_next = 1'b1;
            end else begin
              count_d = count_q - 8'd1;
            end
          end
        end

        ST_LOCKED: begin
          if (judge_valid) begin
            state_d = ST_SCORE;
            who_d   = lock_q;
            right_d = judge_right;
          end
        end

        ST_SCORE: begin
          lock_d = WHO_NONE;
          if (score_advance) begin
            go_next = 1'b1;
          end else begin
            state_d = ST_OPEN;
            if (lock_q == WHO_A) begin
              excl_a_d = 1'b1;
            end else begin
              excl_b_d = 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (go_next) begin
        if (q_num_q == Q_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_OPEN;
          q_num_d  = q_num_q + 8'd1;
          count_d  = CNT_INIT;
          excl_a_d = 1'b0;
          excl_b_d = 1'b0;
        end
      end
    end

    if (state_d == ST_DONE) begin
      who_d   = WHO_NONE;
      right_d = 1'b0;
      lock_d  = WHO_NONE;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_INIT;
      who_q    <= WHO_NONE;
      right_q  <= 1'b0;
      lock_q   <= WHO_NONE;
      q_num_q  <= 8'd0;
      done_q   <= 1'b0;
      excl_a_q <= 1'b0;
      excl_b_q <= 1'b0;
      prio_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      who_q    <= who_d;
      right_q  <= right_d;
      lock_q   <= lock_d;
      q_num_q  <= q_num_d;
      done_q   <= done_d;
      excl_a_q <= excl_a_d;
      excl_b_q <= excl_b_d;
      prio_b_q <= prio_b_d;
    end
  end

  assign count = count_q;
  assign who   = who_q;
  assign right = right_q;
  assign lock  = lock_q;
  assign q_num = q_num_q;
  assign done  = done_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Randomised bench for quiz_round_ctrl: a game-level reference model predicts state and score strobes,
// strobes go through a scoreboard queue popped by an independent monitor.
module tb_quiz_round_ctrl;

  localparam int CI = 5;
  localparam int TD = 2;
  localparam int NQ = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       buzzA = 1'b0;
  logic       buzzB = 1'b0;
  logic       judge_valid = 1'b0;
  logic       judge_right = 1'b0;
  logic       finish = 1'b0;
  logic [7:0] count;
  logic [1:0] who;
  logic       right;
  logic [1:0] lock;
  logic [7:0] q_num;
  logic       done;

  quiz_round_ctrl #(
    .COUNT_INIT(CI),
    .TICK_DIV  (TD),
    .NUM_Q     (NQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .buzzA      (buzzA),
    .buzzB      (buzzB),
    .judge_valid(judge_valid),
    .judge_right(judge_right),
    .finish     (finish),
    .count      (count),
    .who        (who),
    .right      (right),
    .lock       (lock),
    .q_num      (q_num),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game-level reference: players are 1 (A) and 2 (B); owner 0 means nobody holds the floor.
  typedef enum int {M_IDLE, M_OPEN, M_WAIT, M_SCORE, M_OVER} mphase_e;
  mphase_e    m_phase = M_IDLE;
  int         m_count = CI;
  int         m_pres  = 0;
  int         m_q     = 0;
  int         m_owner = 0;
  bit         m_ex[1:2];
  bit         m_prio_b = 1'b0;
  bit         m_right  = 1'b0;
  logic [2:0] exp_q[$];

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_count  = CI;
    m_pres   = 0;
    m_q      = 0;
    m_owner  = 0;
    m_ex[1]  = 1'b0;
    m_ex[2]  = 1'b0;
    m_prio_b = 1'b0;
    m_right  = 1'b0;
    exp_q.delete();
  endtask

  task automatic end_game();
    m_phase = M_OVER;
    m_owner = 0;
    m_right = 1'b0;
  endtask

  task automatic next_question();
    if (m_q == NQ - 1) begin
      end_game();
    end else begin
      m_q++;
      m_count = CI;
      m_pres  = 0;
      m_ex[1] = 1'b0;
      m_ex[2] = 1'b0;
      m_phase = M_OPEN;
    end
  endtask

  task automatic model_step(input bit s, input bit ba, input bit bb,
                            input bit jv, input bit jr, input bit fin);
    bit want[1:2];
    int p;
    bit r;
    if (fin && m_phase != M_IDLE) begin
      end_game();
    end else begin
      case (m_phase)
        M_IDLE: if (s) begin
          m_phase = M_OPEN;
          m_count = CI;
          m_pres  = 0;
          m_ex[1] = 1'b0;
          m_ex[2] = 1'b0;
        end
        M_OPEN: begin
          want[1] = ba && !m_ex[1];
          want[2] = bb && !m_ex[2];
          if (want[1] && want[2]) begin
            m_owner  = m_prio_b ? 2 : 1;
            m_prio_b = !m_prio_b;
            m_phase  = M_WAIT;
          end else if (want[1] || want[2]) begin
            m_owner = want[1] ? 1 : 2;
            m_phase = M_WAIT;
          end else begin
            m_pres = (m_pres + 1) % TD;
            if (m_pres == 0) begin
              if (m_count == 0) next_question();
              else m_count--;
            end
          end
        end
        M_WAIT: if (jv) begin
          m_phase = M_SCORE;
          m_right = jr;
          exp_q.push_back({2'(m_owner), jr});
        end
        M_SCORE: begin
          p       = m_owner;
          r       = m_right;
          m_owner = 0;
          m_right = 1'b0;
          if (r || m_ex[3 - p]) begin
            next_question();
          end else begin
            m_ex[p] = 1'b1;
            m_phase = M_OPEN;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: compares registered outputs every cycle and drains the strobe scoreboard.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      chk("count", 16'(count), 16'(m_count));
      chk("lock", 16'(lock), 16'(m_owner));
      chk("q_num", 16'(q_num), 16'(m_q));
      chk("done", 16'(done), 16'(m_phase == M_OVER));
      if (who !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", 16'(who), 16'(0));
        end else begin
          e = exp_q.pop_front();
          chk("strobe_who_right", 16'({who, right}), 16'(e));
        end
      end else begin
        chk("right_without_who", 16'(right), 16'(0));
        chk("strobe_missing", 16'(exp_q.size()), 16'(0));
        exp_q.delete();
      end
    end
  end

  initial begin
    int abort_at;
    model_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      #2;
      rst = 1'b0;
      {start, buzzA, buzzB, judge_valid, judge_right, finish} = '0;
      model_reset();
      #1;
      chk("rst_count", 16'(count), 16'(CI));
      chk("rst_who", 16'(who), 16'(0));
      chk("rst_right", 16'(right), 16'(0));
      chk("rst_lock", 16'(lock), 16'(0));
      chk("rst_q_num", 16'(q_num), 16'(0));
      chk("rst_done", 16'(done), 16'(0));
      @(negedge clk);
      #2;
      rst = 1'b1;
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 40)) : 1000;
      for (int c = 0; c < 90 && c < abort_at; c++) begin
        @(negedge clk);
        #2;
        start       = ($urandom_range(0, 9) < 7);
        buzzA       = ($urandom_range(0, 4) == 0);
        buzzB       = ($urandom_range(0, 4) == 0);
        judge_valid = ($urandom_range(0, 3) == 0);
        judge_right = $urandom_range(0, 1) == 1;
        finish      = ($urandom_range(0, 63) == 0);
        @(posedge clk);
        model_step(start, buzzA, buzzB, judge_valid, judge_right, finish);
      end
    end
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
